// File: rtl/coin_pulse_conditioner_pkg.sv
// coin_pkg: shared definitions for the coin pulse conditioner.
//   - state_t        : arbitration/lockout FSM states (IDLE, EMIT, LOCK)
//   - CH_*           : channel indices into the per-channel vectors
//   - VAL_*          : coin values credited per accepted coin
//   - CREDIT_MAX     : saturation ceiling of the optional credit total
//   - credit_add()   : saturating add used by the credit accumulator
package coin_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        LOCK
    } state_t;

    localparam int unsigned NUM_CH  = 3;
    localparam int unsigned CH_ONE  = 0;
    localparam int unsigned CH_TWO  = 1;
    localparam int unsigned CH_FIVE = 2;

    localparam logic [7:0] VAL_ONE  = 8'd1;
    localparam logic [7:0] VAL_TWO  = 8'd2;
    localparam logic [7:0] VAL_FIVE = 8'd5;

    localparam logic [7:0] CREDIT_MAX = 8'd255;

    function automatic logic [7:0] credit_add(input logic [7:0] total, input logic [7:0] val);
        logic [8:0] sum;
        sum = {1'b0, total} + {1'b0, val};
        return (sum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : sum[7:0];
    endfunction

endpackage

// File: rtl/coin_pulse_conditioner_if.sv
// Coin sensor / coin strobe bundle between the sensor side and the conditioner.
//   master : drives one_raw, two_raw, five_raw; observes the strobes
//   slave  : the conditioner; samples the raw levels, drives
//            one_pulse, two_pulse, five_pulse, reject, busy
//            (and credit_total when COIN_CREDIT_EN is defined)
interface coin_pulse_conditioner_if;

    logic one_raw;
    logic two_raw;
    logic five_raw;
    logic one_pulse;
    logic two_pulse;
    logic five_pulse;
    logic reject;
    logic busy;
`ifdef COIN_CREDIT_EN
    logic [7:0] credit_total;
`endif

    modport master (
        output one_raw, two_raw, five_raw,
        input  one_pulse, two_pulse, five_pulse, reject, busy
`ifdef COIN_CREDIT_EN
        , input credit_total
`endif
    );

    modport slave (
        input  one_raw, two_raw, five_raw,
        output one_pulse, two_pulse, five_pulse, reject, busy
`ifdef COIN_CREDIT_EN
        , output credit_total
`endif
    );

endinterface

// File: rtl/coin_pulse_conditioner_debounce.sv
// coin_debounce: one coin-sensor channel.
//   clk, reset : system clock, synchronous active-high reset
//   raw        : asynchronous, bouncy sensor level
//   rise       : high for the single cycle in which the debounced level
//                is about to update 0->1
// Two-flop synchroniser, then a counter that must see the synchronised
// level differ from the stable level for DEBOUNCE_CYCLES consecutive
// samples before the stable level follows it.
module coin_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             update;

    // Decoded purely from registers, so the top can register the coin
    // pulse on the same edge that the stable level updates.
    always_comb begin
        update = (sync != stable) && (cnt == CNT_LAST);
        rise   = update && sync;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == stable) begin
                cnt <= '0;
            end else if (update) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/coin_pulse_conditioner.sv
// coin_pulse_conditioner: debounces three coin sensors, arbitrates them
// (FIVE > TWO > ONE) and emits one single-cycle strobe per accepted coin,
// followed by a lockout window during which new detections are rejected.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : coin_pulse_conditioner_if.slave
//                raw inputs one_raw/two_raw/five_raw,
//                strobes one_pulse/two_pulse/five_pulse/reject, level busy
// Optional: define COIN_CREDIT_EN to add bus.credit_total, a saturating
// running total of accepted coin values.
module coin_pulse_conditioner
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned LOCKOUT_CYCLES  = 8,
    parameter int unsigned CNT_W           = 8
) (
    input logic                      clk,
    input logic                      reset,
    coin_pulse_conditioner_if.slave  bus
);

    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);

    logic [NUM_CH-1:0] raw_vec;
    logic [NUM_CH-1:0] rise;

    always_comb begin
        raw_vec          = '0;
        raw_vec[CH_ONE]  = bus.one_raw;
        raw_vec[CH_TWO]  = bus.two_raw;
        raw_vec[CH_FIVE] = bus.five_raw;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        coin_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_vec[g]),
            .rise  (rise[g])
        );
    end

    state_t            state, state_nx;
    logic [CNT_W-1:0]  lock_cnt, lock_cnt_nx;
    logic [NUM_CH-1:0] pulse_q, pulse_nx;
    logic              reject_q, reject_nx;
    logic              busy_q;
    logic              multi;

    always_comb begin
        state_nx    = state;
        lock_cnt_nx = lock_cnt;
        pulse_nx    = '0;
        reject_nx   = 1'b0;
        multi       = (rise[CH_ONE] & rise[CH_TWO]) |
                      (rise[CH_ONE] & rise[CH_FIVE]) |
                      (rise[CH_TWO] & rise[CH_FIVE]);
        case (state)
            IDLE: begin
                if (|rise) begin
                    state_nx  = EMIT;
                    reject_nx = multi;
                    if (rise[CH_FIVE])
                        pulse_nx[CH_FIVE] = 1'b1;
                    else if (rise[CH_TWO])
                        pulse_nx[CH_TWO] = 1'b1;
                    else
                        pulse_nx[CH_ONE] = 1'b1;
                end
            end
            EMIT: begin
                state_nx    = LOCK;
                lock_cnt_nx = LOCK_LOAD;
                reject_nx   = |rise;
            end
            LOCK: begin
                // A detect on the LOCK->IDLE edge is dropped as well.
                reject_nx = |rise;
                if (lock_cnt == '0)
                    state_nx = IDLE;
                else
                    lock_cnt_nx = lock_cnt - 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            lock_cnt <= '0;
            pulse_q  <= '0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            lock_cnt <= lock_cnt_nx;
            pulse_q  <= pulse_nx;
            reject_q <= reject_nx;
            busy_q   <= (state_nx != IDLE);
        end
    end

    assign bus.one_pulse  = pulse_q[CH_ONE];
    assign bus.two_pulse  = pulse_q[CH_TWO];
    assign bus.five_pulse = pulse_q[CH_FIVE];
    assign bus.reject     = reject_q;
    assign bus.busy       = busy_q;

`ifdef COIN_CREDIT_EN
    logic [7:0] credit_q;
    logic [7:0] credit_val;

    always_comb begin
        credit_val = '0;
        if (pulse_q[CH_FIVE])
            credit_val = VAL_FIVE;
        else if (pulse_q[CH_TWO])
            credit_val = VAL_TWO;
        else if (pulse_q[CH_ONE])
            credit_val = VAL_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset)
            credit_q <= '0;
        else if (|pulse_q)
            credit_q <= credit_add(credit_q, credit_val);
    end

    assign bus.credit_total = credit_q;
`endif

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// Testbench for coin_pulse_conditioner (default parameters).
// Expected strobe events {cycle, {reject,five,two,one}} are queued when the
// raw inputs are driven and popped as the strobes appear at the negedge.
// Credit checks are compiled in when COIN_CREDIT_EN is defined.
module tb_coin_pulse_conditioner;

    localparam int unsigned DEB     = 4;
    localparam int unsigned LOCKOUT = 8;
    localparam int unsigned LAT     = DEB + 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    coin_pulse_conditioner_if bus ();

    coin_pulse_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .LOCKOUT_CYCLES  (LOCKOUT),
        .CNT_W           (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  ev;
    } exp_t;

    typedef struct {
        logic [2:0]  raw;
        logic [3:0]  ev;
        int unsigned busy;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[7];
    int unsigned cyc        = 0;
    int unsigned tests      = 0;
    int unsigned fails      = 0;
    int unsigned busy_cnt   = 0;
    int unsigned onehot_err = 0;

    task automatic tick();
        logic [3:0] ev;
        exp_t       e;
        @(negedge clk);
        cyc++;
        ev = {bus.reject, bus.five_pulse, bus.two_pulse, bus.one_pulse};
        if (bus.busy) busy_cnt++;
        if ($countones(ev[2:0]) > 1) onehot_err++;
        if (ev != 4'b0000) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event cyc=%0d got=%b required=none", cyc, ev);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.ev != ev) begin
                    fails++;
                    $display("FAIL event got cyc=%0d ev=%b required cyc=%0d ev=%b",
                             cyc, ev, e.cyc, e.ev);
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic set_raw(input logic [2:0] r);
        bus.five_raw = r[2];
        bus.two_raw  = r[1];
        bus.one_raw  = r[0];
    endtask

    task automatic expect_ev(input logic [3:0] ev, input int unsigned delay);
        exp_t e;
        e.cyc = cyc + delay;
        e.ev  = ev;
        sb.push_back(e);
    endtask

    task automatic end_scenario(input string name);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s missing_events got=%0d required=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_raw(3'b000);
        tick();
        tick();
        reset = 1'b0;
        check("reset_outputs",
              {27'd0, bus.reject, bus.five_pulse, bus.two_pulse, bus.one_pulse, bus.busy}, 32'd0);
        busy_cnt = 0;
    endtask

    initial begin
        vecs[0] = '{raw: 3'b010, ev: 4'b0010, busy: 9};
        vecs[1] = '{raw: 3'b001, ev: 4'b0001, busy: 9};
        vecs[2] = '{raw: 3'b100, ev: 4'b0100, busy: 9};
        vecs[3] = '{raw: 3'b011, ev: 4'b1010, busy: 9};
        vecs[4] = '{raw: 3'b101, ev: 4'b1100, busy: 9};
        vecs[5] = '{raw: 3'b110, ev: 4'b1100, busy: 9};
        vecs[6] = '{raw: 3'b111, ev: 4'b1100, busy: 9};

        set_raw(3'b000);

        // Single and simultaneous rises, each from a clean reset.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            set_raw(vecs[i].raw);
            expect_ev(vecs[i].ev, LAT);
            repeat (10) tick();
            set_raw(3'b000);
            repeat (16) tick();
            end_scenario("table");
            check("table_busy_cycles", busy_cnt, vecs[i].busy);
        end

        // Glitches of 2 and 3 cycles are ignored; 4 cycles is a coin.
        do_reset();
        set_raw(3'b001);
        repeat (2) tick();
        set_raw(3'b000);
        repeat (12) tick();
        set_raw(3'b001);
        repeat (3) tick();
        set_raw(3'b000);
        repeat (12) tick();
        check("glitch_busy", busy_cnt, 0);
        set_raw(3'b001);
        expect_ev(4'b0001, LAT);
        repeat (4) tick();
        set_raw(3'b000);
        repeat (20) tick();
        end_scenario("glitch4");

        // Bounce then steady level.
        do_reset();
        set_raw(3'b001); tick();
        set_raw(3'b000); tick();
        set_raw(3'b001); tick();
        set_raw(3'b000); tick();
        set_raw(3'b001);
        expect_ev(4'b0001, LAT);
        repeat (12) tick();
        set_raw(3'b000);
        repeat (16) tick();
        end_scenario("bounce");

        // Detection inside lockout is rejected; a later fresh coin passes.
        do_reset();
        set_raw(3'b010);
        expect_ev(4'b0010, LAT);
        repeat (3) tick();
        set_raw(3'b011);
        expect_ev(4'b1000, LAT);
        repeat (7) tick();
        set_raw(3'b000);
        begin
            int unsigned n;
            n = 0;
            while (bus.busy && n < 40) begin
                tick();
                n++;
            end
            check("lockout_busy_release", {31'd0, bus.busy}, 32'd0);
        end
        repeat (4) tick();
        set_raw(3'b001);
        expect_ev(4'b0001, LAT);
        repeat (10) tick();
        set_raw(3'b000);
        repeat (16) tick();
        end_scenario("lockout");

        // Reset during LOCK with five_raw held high.
        do_reset();
        set_raw(3'b100);
        expect_ev(4'b0100, LAT);
        repeat (8) tick();
        check("lock_busy_before_reset", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        tick();
        check("midreset_outputs",
              {27'd0, bus.reject, bus.five_pulse, bus.two_pulse, bus.one_pulse, bus.busy}, 32'd0);
        reset = 1'b0;
        expect_ev(4'b0100, LAT);
        repeat (20) tick();
        end_scenario("reset_in_lock");
`ifdef COIN_CREDIT_EN
        check("credit_after_first", {24'd0, bus.credit_total}, 32'd5);
        for (int i = 0; i < 51; i++) begin
            set_raw(3'b000);
            repeat (8) tick();
            set_raw(3'b100);
            expect_ev(4'b0100, LAT);
            repeat (16) tick();
            if (i == 49) check("credit_51_coins", {24'd0, bus.credit_total}, 32'd255);
        end
        end_scenario("credit");
        check("credit_saturated", {24'd0, bus.credit_total}, 32'd255);
`endif
        set_raw(3'b000);
        repeat (10) tick();

        check("pulse_onehot_violations", onehot_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/coin_pulse_conditioner.md
Name: coin_pulse_conditioner

Overview:
- Front end of the vending-machine path; drives the vending FSM's ONE, TWO and FIVE inputs.
- Takes three raw, asynchronous, bouncy coin-sensor levels and synchronises and debounces each one.
- Arbitrates the channels and emits at most one single-cycle coin pulse per accepted coin.
- After each pulse, enforces a lockout window so the downstream FSM can finish its multi-cycle sequence before the next coin arrives.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised level must hold before it is taken as stable (minimum 1).
- LOCKOUT_CYCLES, 8, cycles after an emitted pulse during which new detections are dropped (minimum 1).
- CNT_W, 8, width of the debounce and lockout counters; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, LOCKOUT_CYCLES).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- one_raw  input  1  raw sensor for a 1-unit coin; asynchronous, may bounce.
- two_raw  input  1  raw sensor for a 2-unit coin.
- five_raw  input  1  raw sensor for a 5-unit coin.
- one_pulse  output  1  one-cycle strobe, 1-unit coin accepted.
- two_pulse  output  1  one-cycle strobe, 2-unit coin accepted.
- five_pulse  output  1  one-cycle strobe, 5-unit coin accepted.
- reject  output  1  one-cycle strobe, a detection was dropped (collision or lockout).
- busy  output  1  high while in EMIT or LOCK.

Behaviour:
- Single clock, clk. reset is synchronous and active-high. All state and all outputs are registered.
- Reset values: one_pulse, two_pulse, five_pulse, reject, busy are 0. Synchronisers, stable levels, counters are 0. FSM is in IDLE.
- Reset mid-operation: everything clears on the next edge.
  - A raw level held high through reset is treated as a new coin once it has been debounced after reset.
- Per channel:
  - Two-flop synchroniser produces sync.
  - The debounce counter clears whenever sync equals the stable level. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable level takes sync and the counter clears.
  - A 0->1 stable update raises a registered detect strobe for one cycle. A 1->0 update produces nothing.
- Latency: for a clean raw rise, the pulse is high during the cycle after edge DEBOUNCE_CYCLES+2, counting edges from the first edge that samples the new level. With the default, that is after edge 6.
- Glitches shorter than DEBOUNCE_CYCLES cycles (post-synchroniser) produce no detect.
- FSM states:
  - IDLE: if any detect is high, the selected channel's pulse is registered high and the FSM goes to EMIT.
    - Priority is FIVE > TWO > ONE.
    - If two or more detects are high in the same cycle, only the highest is accepted and reject is also pulsed in that same output cycle.
  - EMIT (1 cycle): the pulse is visible. Go to LOCK and load the lockout counter with LOCKOUT_CYCLES-1.
  - LOCK: decrement each cycle; at 0, return to IDLE.
    - Any detect arriving in EMIT or LOCK is dropped and reject pulses for one cycle.
    - A detect in the same cycle as the LOCK->IDLE transition is also dropped.
- Invariant: at most one of one_pulse, two_pulse, five_pulse is high in any cycle.
- Pulse spacing: consecutive pulses are at least LOCKOUT_CYCLES+1 cycles apart.

Optional Feature:
- Macro: COIN_CREDIT_EN.
- Defined: adds output credit_total [7:0]. It adds 1, 2 or 5 on the edge after each emitted pulse and saturates at 255 (254+5 gives 255). It resets to 0.
- Not defined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package coin_pkg holds:
  - FSM state encoding: IDLE, EMIT, LOCK.
  - Channel index constants: CH_ONE=0, CH_TWO=1, CH_FIVE=2.
  - Coin value constants: 1, 2, 5.
  - CREDIT_MAX=255.
- Sub-module coin_debounce: synchroniser, debounce counter, stable level and rise strobe for one channel; instantiated three times. Arbitration and lockout stay in the top module.

Test Plan:
- Reset, then hold two_raw high for 10 cycles → two_pulse high for exactly 1 cycle, after edge 6 from the first sampling edge. No other pulse, reject=0, busy high for 9 cycles.
- one_raw glitch high for 2 cycles, then 0, with DEBOUNCE_CYCLES=4 → no pulse, no reject.
- one_raw bouncing 1,0,1,0, then steady high → exactly one one_pulse, occurring after the steady level has held 4 cycles.
- five_raw and one_raw rising on the same edge → five_pulse and reject both high in the same cycle, one_pulse never asserted.
- two_raw pulse accepted, then one_raw rise timed to debounce 3 cycles later (inside lockout) → one reject, no one_pulse. A fresh one_raw after busy falls → one_pulse.
- Assert reset during LOCK with five_raw held high → outputs 0 next cycle. A five_pulse fires 6 edges after reset deasserts. With COIN_CREDIT_EN, credit_total=5 afterwards, and 52 five-unit coins saturate it at 255.
